wb_ps2_keyboard: RTL and testbench

//  Wishbone slave that answers CPU bus cycles for the keyboard slot (slave_STB[3]).

---
 rtl/kbd_pkg.sv | 18 +
 rtl/ps2_rx.sv | 122 ++++++++++++
 rtl/wb_ps2_keyboard.sv | 117 +++++++++++
 tb/tb_wb_ps2_keyboard.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard Wishbone slave: register map,
// STAT bit positions and the receiver state encoding.
package kbd_pkg;
   localparam logic KBD_REG_DATA = 1'b0;
   localparam logic KBD_REG_STAT = 1'b1;

   localparam int STAT_OVF   = 0;
   localparam int STAT_PERR  = 1;
   localparam int STAT_FLUSH = 8;
   localparam int DATA_VALID = 8;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;
endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: input synchronizer, frame FSM and a
// mid-frame inactivity timeout. Emits one-cycle pulses per finished frame.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (0) on a PS2C fall
// RX_DATA   | shifting in D0..D7, LSB first
// RX_PARITY | capturing the odd parity bit
// RX_STOP   | checking stop bit and parity, then push or flag error
module ps2_rx
   import kbd_pkg::*;
#(
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ps2c,
   input  logic       ps2d,
   output logic [7:0] code,
   output logic       code_vld,
   output logic       perr_pulse
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [2:0]    c_sync;
   logic [1:0]    d_sync;
   logic          fall;
   logic          bit_in;
   rx_state_t     state, state_nxt;
   logic [7:0]    shift, shift_nxt;
   logic [2:0]    bcnt, bcnt_nxt;
   logic          par, par_nxt;
   logic [TW-1:0] tmr, tmr_nxt;
   logic [7:0]    code_nxt;
   logic          vld_nxt, perr_nxt;

   assign fall   = c_sync[2] & ~c_sync[1];
   assign bit_in = d_sync[1];

   // Synchronizers reset high so release from reset never looks like a fall.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         c_sync     <= 3'b111;
         d_sync     <= 2'b11;
         state      <= RX_IDLE;
         shift      <= '0;
         bcnt       <= '0;
         par        <= 1'b0;
         tmr        <= TW'(TIMEOUT_CYC);
         code       <= '0;
         code_vld   <= 1'b0;
         perr_pulse <= 1'b0;
      end else begin
         c_sync     <= {c_sync[1:0], ps2c};
         d_sync     <= {d_sync[0], ps2d};
         state      <= state_nxt;
         shift      <= shift_nxt;
         bcnt       <= bcnt_nxt;
         par        <= par_nxt;
         tmr        <= tmr_nxt;
         code       <= code_nxt;
         code_vld   <= vld_nxt;
         perr_pulse <= perr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      shift_nxt = shift;
      bcnt_nxt  = bcnt;
      par_nxt   = par;
      code_nxt  = code;
      vld_nxt   = 1'b0;
      perr_nxt  = 1'b0;
      if (state == RX_IDLE || fall)
         tmr_nxt = TW'(TIMEOUT_CYC);
      else if (tmr != '0)
         tmr_nxt = tmr - 1'b1;
      else
         tmr_nxt = tmr;

      unique case (state)
         RX_IDLE: begin
            if (fall && !bit_in) begin
               state_nxt = RX_DATA;
               bcnt_nxt  = '0;
            end
         end
         RX_DATA: begin
            if (fall) begin
               shift_nxt = {bit_in, shift[7:1]};
               bcnt_nxt  = bcnt + 1'b1;
               if (bcnt == 3'd7)
                  state_nxt = RX_PARITY;
            end
         end
         RX_PARITY: begin
            if (fall) begin
               par_nxt   = bit_in;
               state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (fall) begin
               state_nxt = RX_IDLE;
               if (bit_in) begin
                  if (^{shift, par}) begin
                     vld_nxt  = 1'b1;
                     code_nxt = shift;
                  end else begin
                     perr_nxt = 1'b1;
                  end
               end
            end
         end
         default: state_nxt = RX_IDLE;
      endcase

      // Inactivity mid-frame abandons the partial byte.
      if (state != RX_IDLE && !fall && tmr == '0)
         state_nxt = RX_IDLE;
   end
endmodule

// File: rtl/wb_ps2_keyboard.sv
// Wishbone keyboard slave: scancode FIFO fed by ps2_rx, DATA/STAT registers
// and the single-accept STB/ACK handshake shared with the other slaves.
module wb_ps2_keyboard
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        STB,
   input  logic        WE,
   input  logic [31:0] ADDR,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        ACK,
   input  logic        PS2C,
   input  logic        PS2D,
   output logic        IRQ
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    rx_code;
   logic          rx_vld, rx_perr;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          ovf, perr;
   logic          empty, full, accept, sel_stat;
   logic          do_pop, do_push, do_flush, clr_ovf, clr_perr, ovf_set;
   logic [7:0]    count8;
   logic [31:0]   rd_word;
   logic          unused_bits;

   assign unused_bits = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:9], DAT_I[7:2]};

   ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .clk        (clk),
      .rstn       (rstn),
      .ps2c       (PS2C),
      .ps2d       (PS2D),
      .code       (rx_code),
      .code_vld   (rx_vld),
      .perr_pulse (rx_perr)
   );

   always_comb begin
      empty    = (count == '0);
      full     = (count == CW'(FIFO_DEPTH));
      count8   = 8'(count);
      accept   = STB & ~ACK;
      sel_stat = (ADDR[2] == KBD_REG_STAT);
      do_pop   = accept & ~WE & ~sel_stat & ~empty;
      do_flush = accept & WE & sel_stat & DAT_I[STAT_FLUSH];
      clr_ovf  = accept & WE & sel_stat & DAT_I[STAT_OVF];
      clr_perr = accept & WE & sel_stat & DAT_I[STAT_PERR];
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      do_push  = rx_vld & (~full | do_pop) & ~do_flush;
      ovf_set  = rx_vld & full & ~do_pop;
      rd_word  = '0;
      if (!WE) begin
         if (sel_stat)
            rd_word = {16'b0, count8, 6'b0, perr, ovf};
         else if (!empty)
            rd_word = {23'b0, 1'b1, mem[rptr]};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wptr] <= rx_code;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         perr  <= 1'b0;
         ACK   <= 1'b0;
         DAT_O <= '0;
         IRQ   <= 1'b0;
      end else begin
         if (do_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (do_push)
               wptr <= wptr + 1'b1;
            if (do_pop)
               rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
         end

         if (ovf_set)
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;
         if (rx_perr)
            perr <= 1'b1;
         else if (clr_perr)
            perr <= 1'b0;

         if (accept) begin
            ACK   <= 1'b1;
            DAT_O <= rd_word;
         end else if (!STB) begin
            ACK <= 1'b0;
         end

         IRQ <= ~empty;
      end
   end
endmodule

// File: tb/tb_wb_ps2_keyboard.sv
// Directed bench for wb_ps2_keyboard: PS/2 frames and bus cycles drive the
// DUT, expected read data is queued and checked when ACK rises.
`timescale 1ns/1ps
module tb_wb_ps2_keyboard;
   localparam int HP      = 20;
   localparam int TOUT    = 200;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        STB = 1'b0;
   logic        WE = 1'b0;
   logic [31:0] ADDR = '0;
   logic [31:0] DAT_I = '0;
   logic [31:0] DAT_O;
   logic        ACK;
   logic        PS2C = 1'b1;
   logic        PS2D = 1'b1;
   logic        IRQ;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          chk;
      logic [31:0] exp;
      string       nm;
   } sb_t;
   sb_t sb[$];

   wb_ps2_keyboard #(.FIFO_DEPTH(16), .TIMEOUT_CYC(TOUT)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .STB   (STB),
      .WE    (WE),
      .ADDR  (ADDR),
      .DAT_I (DAT_I),
      .DAT_O (DAT_O),
      .ACK   (ACK),
      .PS2C  (PS2C),
      .PS2D  (PS2D),
      .IRQ   (IRQ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: every rising ACK retires one queued bus cycle.
   logic ack_q = 1'b0;
   always @(negedge clk) begin
      if (ACK && !ack_q) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack actual=%h required=none", DAT_O);
         end else begin
            sb_t e;
            e = sb.pop_front();
            if (e.chk)
               chk(e.nm, DAT_O, e.exp);
         end
      end
      ack_q = ACK;
   end

   task automatic bus_cycle(input logic we, input logic a2, input logic [31:0] wd);
      @(negedge clk);
      STB   = 1'b1;
      WE    = we;
      ADDR  = {29'b0, a2, 2'b00};
      DAT_I = wd;
      begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!ACK && n < 20);
         if (!ACK) chk("ack_timeout", {31'b0, ACK}, 32'd1);
      end
      STB = 1'b0;
      begin
         int n = 0;
         while (ACK && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (ACK) chk("ack_release", {31'b0, ACK}, 32'd0);
      end
   endtask

   task automatic bus_rd(input logic a2, input logic [31:0] exp, input string nm);
      sb.push_back('{1'b1, exp, nm});
      bus_cycle(1'b0, a2, 32'd0);
   endtask

   task automatic bus_wr(input logic a2, input logic [31:0] wd);
      sb.push_back('{1'b0, 32'd0, "wr"});
      bus_cycle(1'b1, a2, wd);
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         PS2D = f[i];
         repeat (HP) @(negedge clk);
         PS2C = 1'b0;
         repeat (HP) @(negedge clk);
         PS2C = 1'b1;
      end
      PS2D = 1'b1;
      repeat (HP) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] code, input bit flip_par);
      logic par;
      par = ~(^code) ^ flip_par;
      send_bits({1'b1, par, code, 1'b0}, 11);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   logic [7:0] codes [17];

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ack", {31'b0, ACK}, 32'd0);
      chk("rst_dat", DAT_O, 32'd0);
      chk("rst_irq", {31'b0, IRQ}, 32'd0);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      bus_rd(1'b1, 32'h0000_0000, "rst_stat");

      // 1: good frame
      send_frame(8'h1C, 1'b0);
      repeat (3) @(negedge clk);
      chk("t1_irq", {31'b0, IRQ}, 32'd1);
      bus_rd(1'b1, 32'h0000_0100, "t1_stat");
      bus_rd(1'b0, 32'h0000_011C, "t1_data");
      repeat (3) @(negedge clk);
      chk("t1_irq_clr", {31'b0, IRQ}, 32'd0);

      // 2: parity error, then clear
      send_frame(8'h1C, 1'b1);
      repeat (3) @(negedge clk);
      bus_rd(1'b1, 32'h0000_0002, "t2_perr");
      bus_wr(1'b1, 32'h0000_0002);
      bus_rd(1'b1, 32'h0000_0000, "t2_perr_clr");

      // 3: overflow
      for (int i = 0; i < 17; i++) begin
         codes[i] = 8'h40 + 8'(i * 3);
         send_frame(codes[i], 1'b0);
      end
      bus_rd(1'b1, 32'h0000_1001, "t3_stat_full");
      for (int i = 0; i < 16; i++)
         bus_rd(1'b0, {23'b0, 1'b1, codes[i]}, $sformatf("t3_data%0d", i));
      bus_rd(1'b0, 32'h0000_0000, "t3_empty");
      bus_wr(1'b1, 32'h0000_0001);
      bus_rd(1'b1, 32'h0000_0000, "t3_ovf_clr");

      // 4: truncated frame times out
      send_bits({1'b1, 1'b0, 8'hAA, 1'b0}, 6);
      repeat (TOUT + 50) @(negedge clk);
      send_frame(8'hF0, 1'b0);
      bus_rd(1'b1, 32'h0000_0100, "t4_stat");
      bus_rd(1'b0, 32'h0000_01F0, "t4_data");
      bus_rd(1'b0, 32'h0000_0000, "t4_empty");

      // 5: long STB pops once
      send_frame(8'h21, 1'b0);
      send_frame(8'h22, 1'b0);
      sb.push_back('{1'b1, 32'h0000_0121, "t5_hold_data"});
      @(negedge clk);
      STB  = 1'b1;
      WE   = 1'b0;
      ADDR = 32'h0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         chk($sformatf("t5_ack_c%0d", k), {31'b0, ACK}, 32'd1);
      end
      STB = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_ack_drop", {31'b0, ACK}, 32'd0);
      bus_rd(1'b1, 32'h0000_0100, "t5_stat");
      bus_rd(1'b0, 32'h0000_0122, "t5_data2");

      // 6: reset mid-frame and mid-bus-cycle
      send_frame(8'h31, 1'b0);
      send_frame(8'h32, 1'b0);
      send_frame(8'h33, 1'b0);
      send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 4);
      sb.push_back('{1'b1, 32'h0000_0300, "t6_stat_pre"});
      @(negedge clk);
      STB  = 1'b1;
      WE   = 1'b0;
      ADDR = 32'h4;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("t6_rst_ack", {31'b0, ACK}, 32'd0);
      chk("t6_rst_irq", {31'b0, IRQ}, 32'd0);
      chk("t6_rst_dat", DAT_O, 32'd0);
      STB = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      bus_rd(1'b1, 32'h0000_0000, "t6_stat_post");
      send_frame(8'h5A, 1'b0);
      repeat (3) @(negedge clk);
      chk("t6_irq", {31'b0, IRQ}, 32'd1);
      bus_rd(1'b0, 32'h0000_015A, "t6_data");

      repeat (5) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
